usb_tx_serializer: RTL and testbench
====================================

# usb_tx_serializer

Full-speed USB transmit serializer: the transmit-side counterpart of the receive bit-timing and destuffing path. Accepts packet bytes over a valid/ready handshake, then emits SYNC, the LSB-first, bit-stuffed, NRZI-encoded payload, and EOP on D+/D−. It uses the receiver's 8/8/9-clock bit pattern (25 clocks per 3 bits), so both ends share one bit grid. It sits between the protocol controller's TX FIFO and the bus driver.

## Interface
- STUFF_LEN, 6, number of consecutive 1s after which a 0 is inserted
- SYNC_PATTERN, 8'h80, SYNC byte, sent LSB first
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tx_start  in  1  one-cycle request to begin a packet; ignored while tx_busy
- tx_data  in  8  packet byte
- tx_last  in  1  qualifies tx_data as the final byte
- tx_valid  in  1  tx_data/tx_last valid
- tx_ready  out  1  byte fetch window; transfer occurs when tx_valid && tx_ready
- tx_append_crc  in  1  present only with USB_TX_CRC16_EN; sampled with tx_start
- d_plus  out  1  registered D+ line
- d_minus  out  1  registered D− line
- tx_busy  out  1  packet in progress
- tx_done  out  1  one-cycle pulse after EOP completes
- tx_error  out  1  one-cycle pulse on underrun

## Operation
- Line states: J=(1,0), K=(0,1), SE0=(0,0). Idle drives J.
- Reset values: d_plus=1, d_minus=0, tx_busy=0, tx_ready=0, tx_done=0, tx_error=0. The state machine enters IDLE, the ones count clears and the bit timer clears.
- States: IDLE → SYNC → DATA → (CRC) → EOP_SE0 → EOP_J → IDLE.
- IDLE: tx_start → SYNC; tx_busy=1 from the next cycle.
- SYNC: 8 bits of SYNC_PATTERN, giving K J K J K J K K on the line.
- NRZI: data bit 0 toggles the line; data bit 1 holds it.
- Bit stuffing: the ones counter counts consecutive transmitted 1s, including SYNC. When it reaches STUFF_LEN, one extra 0 bit period is inserted before the next bit and the counter clears. A pending stuff bit after the final data/CRC bit is sent before EOP.
- Byte fetch: tx_ready=1 in exactly one cycle, the bit strobe that ends SYNC bit 7 or data bit 7 of a non-last byte. tx_ready is combinational from state, strobe and bit index. A transfer loads the shift register and captures tx_last.
- Underrun: tx_valid=0 in the fetch cycle → tx_error pulse that cycle, then go directly to EOP_SE0 (after any pending stuff bit).
- After the tx_last byte: go to CRC if enabled, else EOP_SE0.
- EOP: SE0 for 2 bit periods, then J for 1 bit period.
- tx_done pulses and tx_busy falls in the same cycle, at the strobe ending EOP_J.
- A reset mid-packet aborts immediately: J on the line next cycle, with no EOP.

## Timing
- Bit timer: a 5-bit counter 1..25, cleared on tx_start. The strobe fires at counts 8, 16 and 25; at 25 it wraps to 1.
- Bit lengths in a packet therefore run 8,8,9,8,8,9,…
- The first SYNC bit (K) appears on the line the cycle after tx_start.
- Line outputs change only in the cycle after a strobe (registered), except for the first bit.
- SYNC duration is 66 clocks; EOP duration is 3 bit periods of the pattern.
- Simultaneous rst and tx_start: rst wins.

## Configuration
- USB_TX_CRC16_EN defined:
  - Port tx_append_crc exists.
  - If it is sampled as 1, a CRC16 is computed over every byte after the first (the PID).
  - Polynomial 0x8005 (reflected 0xA001), init 0xFFFF.
  - The complement is appended as 16 bits, LSB first, and is stuffed and NRZI-encoded like data.
- Macro undefined: port absent, CRC state absent, DATA → EOP_SE0 directly.

## Structure
- Package usb_tx_pkg holds:
  - the state enum
  - the J/K/SE0 encodings
  - SYNC_PATTERN default
  - the bit strobe counts 8/16/25
  - the CRC16 polynomial and init constants
- Sub-module usb_tx_bit_timer: the clear/enable 1..25 counter emitting bit_strobe.

## Test plan
- Reset: rst high 2 cycles mid-idle → (d_plus,d_minus)=(1,0), tx_busy=0, tx_ready=0, tx_done=0.
- ACK packet:
  - Stimulus: tx_start, then byte 0xD2 with tx_last=1.
  - Line: K J K J K J K K, then the NRZI of 0,1,0,0,1,0,1,1, then SE0 SE0 J.
  - tx_done 1 pulse; bit lengths follow 8/8/9.
- Stuffing: bytes 0xFF, 0x01(last) → a 0 is inserted after bit 4 of 0xFF (SYNC's trailing 1 counts), with the K/J toggle at that point; total data bit periods = 17.
- Underrun: 2-byte packet with tx_valid=0 at the second fetch → tx_error 1 cycle, EOP begins on the next bit period, tx_done follows.
- Mid-packet reset: rst during DATA bit 3 → J the next cycle, tx_busy=0, no tx_done.
- CRC (macro defined):
  - Stimulus: tx_append_crc=1, single byte 0xC3 last.
  - Response: 16 zero CRC bits (a line toggle every bit period) after the byte, then EOP.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB transmit serializer.
// The S_CRC state exists only when USB_TX_CRC16_EN is defined.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
`ifdef USB_TX_CRC16_EN
    S_CRC,
`endif
    S_EOP_SE0,
    S_EOP_J
  } tx_state_e;

  // {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_PATTERN_DEF = 8'h80;

  localparam logic [4:0] STROBE_A = 5'd8;
  localparam logic [4:0] STROBE_B = 5'd16;
  localparam logic [4:0] STROBE_C = 5'd25;

  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  // One byte of reflected CRC16, LSB of the data first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// 1..25 bit-grid counter; strobes at counts 8, 16 and 25 give the 8/8/9 bit lengths.
// Clearing restarts the grid so the cycle after the clear is count 1.
module usb_tx_bit_timer
  import usb_tx_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_strobe
);

  logic [4:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= 5'd1;
    else if (i_en)  r_cnt <= (r_cnt == STROBE_C) ? 5'd1 : r_cnt + 5'd1;
  end

  assign o_bit_strobe = i_en &&
                        ((r_cnt == STROBE_A) || (r_cnt == STROBE_B) || (r_cnt == STROBE_C));

endmodule

// File: rtl/usb_tx_serializer.sv
// Full-speed USB TX: SYNC, LSB-first bit-stuffed NRZI payload, EOP on D+/D-.
// Define USB_TX_CRC16_EN to add the tx_append_crc port and the CRC16 trailer.
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN    = 6,
  parameter logic [7:0]  SYNC_PATTERN = SYNC_PATTERN_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
`ifdef USB_TX_CRC16_EN
  input  logic       i_tx_append_crc,
`endif
  output logic       o_d_plus,
  output logic       o_d_minus,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_tx_error
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  tx_state_e          r_state, w_state;
  logic [3:0]         r_idx, w_idx;
  logic [7:0]         r_shift, w_shift;
  logic               r_last, w_last;
  logic               r_stuff, w_stuff;
  logic [ONES_W-1:0]  r_ones, w_ones;
  logic               r_dp, w_dp, r_dm, w_dm;
  logic               r_done, w_done;
  logic               w_emit, w_bit, w_strobe, w_fetch, w_data_state;
`ifdef USB_TX_CRC16_EN
  logic [15:0]        r_crc, w_crc;
  logic               r_crc_en, w_crc_en;
`endif

  usb_tx_bit_timer u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        ((r_state == S_IDLE) && i_tx_start),
    .i_en         (r_state != S_IDLE),
    .o_bit_strobe (w_strobe)
  );

  assign w_fetch = w_strobe && !r_stuff && (r_idx == 4'd7) &&
                   ((r_state == S_SYNC) || ((r_state == S_DATA) && !r_last));

  assign w_data_state = (r_state == S_SYNC) || (r_state == S_DATA)
`ifdef USB_TX_CRC16_EN
                        || (r_state == S_CRC)
`endif
                        ;

  assign o_tx_ready = w_fetch;
  assign o_tx_error = w_fetch && !i_tx_valid;
  assign o_tx_busy  = (r_state != S_IDLE);
  assign o_tx_done  = r_done;
  assign o_d_plus   = r_dp;
  assign o_d_minus  = r_dm;

  // (state, idx) points at the logical bit on the line; while a stuff bit
  // is on the line it already points at the next logical bit.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_last  = r_last;
    w_stuff = r_stuff;
    w_ones  = r_ones;
    w_dp    = r_dp;
    w_dm    = r_dm;
    w_done  = 1'b0;
    w_emit  = 1'b0;
    w_bit   = 1'b1;
`ifdef USB_TX_CRC16_EN
    w_crc    = r_crc;
    w_crc_en = r_crc_en;
`endif
    if (r_state == S_IDLE) begin
      if (i_tx_start) begin
        w_state = S_SYNC;
        w_idx   = '0;
        w_ones  = '0;
        w_stuff = 1'b0;
        w_last  = 1'b0;
        w_emit  = 1'b1;
`ifdef USB_TX_CRC16_EN
        w_crc    = CRC16_INIT;
        w_crc_en = i_tx_append_crc;
`endif
      end
    end else if (w_strobe) begin
      if (!r_stuff) begin
        case (r_state)
          S_SYNC, S_DATA: begin
            if (r_idx != 4'd7) begin
              w_idx = r_idx + 4'd1;
            end else if ((r_state == S_DATA) && r_last) begin
              w_idx = '0;
`ifdef USB_TX_CRC16_EN
              w_state = r_crc_en ? S_CRC : S_EOP_SE0;
`else
              w_state = S_EOP_SE0;
`endif
            end else if (i_tx_valid) begin
              w_state = S_DATA;
              w_idx   = '0;
              w_shift = i_tx_data;
              w_last  = i_tx_last;
`ifdef USB_TX_CRC16_EN
              if (r_state == S_DATA) w_crc = crc16_byte(r_crc, i_tx_data);
`endif
            end else begin
              w_state = S_EOP_SE0;
              w_idx   = '0;
            end
          end
`ifdef USB_TX_CRC16_EN
          S_CRC: begin
            if (r_idx == 4'd15) begin
              w_state = S_EOP_SE0;
              w_idx   = '0;
            end else begin
              w_idx = r_idx + 4'd1;
            end
          end
`endif
          S_EOP_SE0: begin
            if (r_idx == 4'd1) begin
              w_state = S_EOP_J;
              w_idx   = '0;
            end else begin
              w_idx = r_idx + 4'd1;
            end
          end
          S_EOP_J: begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end
          default: w_state = S_IDLE;
        endcase
      end
      if (!r_stuff && w_data_state && (r_ones == ONES_W'(STUFF_LEN))) begin
        w_stuff = 1'b1;
        w_ones  = '0;
        w_dp    = ~r_dp;
        w_dm    = r_dp;
      end else begin
        w_stuff = 1'b0;
        w_emit  = 1'b1;
      end
    end

    case (w_state)
      S_SYNC:  w_bit = SYNC_PATTERN[w_idx[2:0]];
      S_DATA:  w_bit = w_shift[w_idx[2:0]];
`ifdef USB_TX_CRC16_EN
      S_CRC:   w_bit = ~w_crc[w_idx];
`endif
      default: w_bit = 1'b1;
    endcase

    if (w_emit) begin
      case (w_state)
        S_EOP_SE0: begin
          w_dp   = 1'b0;
          w_dm   = 1'b0;
          w_ones = '0;
        end
        S_EOP_J, S_IDLE: begin
          w_dp   = 1'b1;
          w_dm   = 1'b0;
          w_ones = '0;
        end
        default: begin
          w_dp   = w_bit ? r_dp : ~r_dp;
          w_dm   = ~w_dp;
          w_ones = w_bit ? (w_ones + ONES_W'(1)) : '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_stuff <= 1'b0;
      r_ones  <= '0;
      r_dp    <= 1'b1;
      r_dm    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_last  <= w_last;
      r_stuff <= w_stuff;
      r_ones  <= w_ones;
      r_dp    <= w_dp;
      r_dm    <= w_dm;
      r_done  <= w_done;
    end
  end

`ifdef USB_TX_CRC16_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc    <= CRC16_INIT;
      r_crc_en <= 1'b0;
    end else begin
      r_crc    <= w_crc;
      r_crc_en <= w_crc_en;
    end
  end
`endif

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench for usb_tx_serializer: a line-symbol model fills a queue,
// and each 8/8/9 bit period of the DUT output is checked against it.
module tb_usb_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_error;
`ifdef USB_TX_CRC16_EN
  logic       tx_append_crc = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  usb_tx_serializer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tx_start (tx_start),
    .i_tx_data  (tx_data),
    .i_tx_last  (tx_last),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
`ifdef USB_TX_CRC16_EN
    .i_tx_append_crc (tx_append_crc),
`endif
    .o_d_plus   (d_plus),
    .o_d_minus  (d_minus),
    .o_tx_busy  (tx_busy),
    .o_tx_done  (tx_done),
    .o_tx_error (tx_error)
  );

  logic [7:0] pkt [0:7];
  int         pkt_n;
  int         underrun_at;
  logic       use_crc = 1'b0;
  logic [1:0] exp_q [$];
  logic       m_lvl;
  int         m_ones;

  task automatic push_bit(input logic b);
    if (!b) begin
      m_lvl  = ~m_lvl;
      m_ones = 0;
    end else begin
      m_ones++;
    end
    exp_q.push_back(m_lvl ? 2'b10 : 2'b01);
    if (m_ones == 6) begin
      m_lvl  = ~m_lvl;
      m_ones = 0;
      exp_q.push_back(m_lvl ? 2'b10 : 2'b01);
    end
  endtask

  task automatic build_expected();
    int          nb;
    logic [7:0]  s;
    logic [15:0] crc;
    logic        fb;
    exp_q.delete();
    m_lvl  = 1'b1;
    m_ones = 0;
    s = 8'h80;
    for (int i = 0; i < 8; i++) push_bit(s[i]);
    nb  = (underrun_at >= 0) ? underrun_at : pkt_n;
    crc = 16'hFFFF;
    for (int k = 0; k < nb; k++) begin
      s = pkt[k];
      for (int i = 0; i < 8; i++) push_bit(s[i]);
      if (k > 0)
        for (int i = 0; i < 8; i++) begin
          fb  = crc[0] ^ s[i];
          crc = crc >> 1;
          if (fb) crc = crc ^ 16'hA001;
        end
    end
    if (use_crc && underrun_at < 0)
      for (int i = 0; i < 16; i++) push_bit(~crc[i]);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // Drives one packet; poke >= 0 raises tx_start at that cycle while busy.
  task automatic run_packet(input string name, input int poke);
    int n_per, p, pos, c, ptr, n_rdy, n_err, exp_rdy, exp_err, len;
    logic [1:0] exp_s;
    build_expected();
    n_per   = exp_q.size();
    exp_rdy = (underrun_at >= 0) ? underrun_at + 1 : pkt_n;
    exp_err = (underrun_at >= 0) ? 1 : 0;
    @(negedge clk);
    tx_start = 1'b1;
`ifdef USB_TX_CRC16_EN
    tx_append_crc = use_crc;
`endif
    @(negedge clk);
    tx_start = 1'b0;
    p = 0; pos = 0; c = 0; ptr = 0; n_rdy = 0; n_err = 0;
    exp_s = 2'b10;
    while (p < n_per) begin
      if (pos == 0) exp_s = exp_q.pop_front();
      tx_start = (c == poke);
      tx_valid = (ptr < pkt_n) && (ptr != underrun_at);
      tx_data  = (ptr < pkt_n) ? pkt[ptr] : 8'h00;
      tx_last  = (ptr == pkt_n - 1);
      #1;
      n_tests++;
      if ({d_plus, d_minus} !== exp_s) begin
        n_fail++;
        $display("FAIL %s line period %0d cycle %0d: got %b expected %b",
                 name, p, c, {d_plus, d_minus}, exp_s);
      end
      n_tests++;
      if (tx_busy !== 1'b1 || tx_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy/done cycle %0d: got %b%b expected 10", name, c, tx_busy, tx_done);
      end
      n_tests++;
      if (tx_error !== (tx_ready && !tx_valid)) begin
        n_fail++;
        $display("FAIL %s error cycle %0d: got %b expected %b", name, c, tx_error,
                 tx_ready && !tx_valid);
      end
      if (tx_ready === 1'b1) begin
        n_rdy++;
        if (tx_valid) ptr++;
      end
      if (tx_error === 1'b1) n_err++;
      @(negedge clk);
      c++;
      pos++;
      len = (p % 3 == 2) ? 9 : 8;
      if (pos == len) begin
        pos = 0;
        p++;
      end
    end
    tx_start = 1'b0;
    tx_valid = 1'b0;
    #1;
    n_tests++;
    if (n_rdy != exp_rdy) begin
      n_fail++;
      $display("FAIL %s ready count: got %0d expected %0d", name, n_rdy, exp_rdy);
    end
    n_tests++;
    if (n_err != exp_err) begin
      n_fail++;
      $display("FAIL %s error count: got %0d expected %0d", name, n_err, exp_err);
    end
    n_tests++;
    if (tx_done !== 1'b1 || tx_busy !== 1'b0 || {d_plus, d_minus} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s end: done %b busy %b line %b expected 1 0 10", name, tx_done, tx_busy,
               {d_plus, d_minus});
    end
    @(negedge clk);
    n_tests++;
    if (tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done width: got %b expected 0", name, tx_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset during: got %b expected 100000",
               {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset after: got %b expected 100000",
               {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error});
    end
  endtask

  task automatic test_ack();
    pkt[0] = 8'hD2; pkt_n = 1; underrun_at = -1; use_crc = 1'b0;
    run_packet("ack", -1);
  endtask

  task automatic test_stuffing();
    pkt[0] = 8'hFF; pkt[1] = 8'h01; pkt_n = 2; underrun_at = -1; use_crc = 1'b0;
    run_packet("stuff", -1);
  endtask

  task automatic test_underrun();
    pkt[0] = 8'h5A; pkt[1] = 8'h33; pkt_n = 2; underrun_at = 1; use_crc = 1'b0;
    run_packet("underrun", -1);
  endtask

  task automatic test_mid_reset();
    logic saw_done;
    tx_data = 8'hA5; tx_last = 1'b1; tx_valid = 1'b1;
    @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (93) @(negedge clk);
    n_tests++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset busy before: got %b expected 1", tx_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({d_plus, d_minus} !== 2'b10 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset abort: line %b busy %b expected 10 0", {d_plus, d_minus}, tx_busy);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_done === 1'b1 || {d_plus, d_minus} !== 2'b10) saw_done = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset quiet: got activity %b expected 0", saw_done);
    end
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    pkt[0] = 8'h4B; pkt[1] = 8'hFF; pkt[2] = 8'hFF; pkt[3] = 8'h3F;
    pkt[4] = 8'($urandom_range(0, 255));
    pkt_n = 5; underrun_at = -1; use_crc = 1'b0;
    run_packet("b2b_a", 100);
    pkt[0] = 8'h69; pkt[1] = 8'h00; pkt[2] = 8'h80; pkt_n = 3;
    run_packet("b2b_b", -1);
  endtask

`ifdef USB_TX_CRC16_EN
  task automatic test_crc();
    pkt[0] = 8'hC3; pkt_n = 1; underrun_at = -1; use_crc = 1'b1;
    run_packet("crc_pid", -1);
    pkt[0] = 8'hC3; pkt[1] = 8'h01; pkt[2] = 8'hFE; pkt_n = 3;
    run_packet("crc_data", -1);
    use_crc = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_ack();
    test_stuffing();
    test_underrun();
    test_mid_reset();
    test_ack();
    test_back_to_back();
`ifdef USB_TX_CRC16_EN
    test_crc();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
